// File: rtl/divergent_scheduler.sv
// divergent_scheduler: per-core block sequencer with per-thread PCs, min-PC scheduling and implicit reconvergence
module divergent_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH = 8,
  parameter int TC_WIDTH = $clog2(THREADS_PER_BLOCK + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [TC_WIDTH-1:0] thread_count,
  input  logic decoded_mem_read_enable,
  input  logic decoded_mem_write_enable,
  input  logic decoded_ret,
  input  logic [2:0] fetcher_state,
  input  logic [THREADS_PER_BLOCK-1:0][1:0] lsu_state,
  input  logic [THREADS_PER_BLOCK-1:0][PC_WIDTH-1:0] next_pc,
  output logic [PC_WIDTH-1:0] current_pc,
  output logic [THREADS_PER_BLOCK-1:0] thread_mask,
  output logic diverged,
  output logic [2:0] core_state,
  output logic done
);
  localparam int N = THREADS_PER_BLOCK;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE, DONE} state_t;
  state_t state, nxt;
  logic [N-1:0][PC_WIDTH-1:0] thread_pc, upd_pc;
  logic [N-1:0] enabled, finished, upd_fin, live, new_mask, en_launch;
  logic [PC_WIDTH-1:0] sel;
  logic busy;
  logic unused_mem;
  assign unused_mem = ^{decoded_mem_read_enable, decoded_mem_write_enable};
  assign core_state = state;
  // Post-update thread view: the next instruction is picked from the values UPDATE is about to write.
  always_comb begin
    busy = 1'b0;
    sel = '1;
    upd_pc = thread_pc;
    upd_fin = finished;
    en_launch = '0;
    new_mask = '0;
    live = '0;
    for (int i = 0; i < N; i++) begin
      en_launch[i] = i < int'(thread_count);
      busy |= thread_mask[i] && (lsu_state[i] == 2'b01 || lsu_state[i] == 2'b10);
      if (state == UPDATE && thread_mask[i]) begin
        upd_pc[i] = decoded_ret ? thread_pc[i] : next_pc[i];
        upd_fin[i] = finished[i] | decoded_ret;
      end
    end
    live = enabled & ~upd_fin;
    for (int i = 0; i < N; i++)
      if (live[i] && upd_pc[i] < sel) sel = upd_pc[i];
    for (int i = 0; i < N; i++)
      new_mask[i] = live[i] && upd_pc[i] == sel;
  end
  always_ff @(posedge clk)
    state <= !reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !start ? IDLE : (thread_count == '0 ? DONE : FETCH);
      FETCH:   nxt = fetcher_state == 3'b010 ? DECODE : FETCH;
      DECODE:  nxt = REQUEST;
      REQUEST: nxt = WAIT;
      WAIT:    nxt = busy ? WAIT : EXECUTE;
      EXECUTE: nxt = UPDATE;
      UPDATE:  nxt = live == '0 ? DONE : FETCH;
      default: nxt = DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      current_pc <= '0;
      thread_mask <= '0;
      diverged <= 1'b0;
      done <= 1'b0;
      thread_pc <= '0;
      enabled <= '0;
      finished <= '0;
    end else if (state == IDLE && start) begin
      enabled <= en_launch;
      finished <= '0;
      thread_pc <= '0;
      current_pc <= '0;
      thread_mask <= en_launch;
      diverged <= 1'b0;
      done <= thread_count == '0;
    end else if (state == UPDATE) begin
      thread_pc <= upd_pc;
      finished <= upd_fin;
      done <= live == '0;
      thread_mask <= live == '0 ? '0 : new_mask;
      diverged <= live != '0 && new_mask != live;
      current_pc <= live == '0 ? current_pc : sel;
    end
  end
endmodule

// File: tb/tb_divergent_scheduler.sv
// tb_divergent_scheduler: bench acts as fetcher/LSU/PC units and scores the scheduler's choices
module tb_divergent_scheduler;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, rd = 1'b0, wr = 1'b0, ret = 1'b0;
  logic [2:0] thread_count = '0, fetcher_state = 3'b010;
  logic [3:0][1:0] lsu_state = '0;
  logic [3:0][7:0] next_pc = '0;
  logic [7:0] current_pc;
  logic [3:0] thread_mask;
  logic diverged, done;
  logic [2:0] core_state;
  int vectors = 0, miscompares = 0, cyc = 0, t0 = 0;
  typedef struct packed {
    logic launch;
    logic [7:0] pc;
    logic [3:0][7:0] npc;
    logic ret;
    logic [7:0] epc;
    logic [3:0] emask;
    logic ediv;
    logic edone;
  } vec_t;
  typedef struct packed {
    logic [7:0] pc;
    logic [3:0] mask;
    logic div;
    logic done;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  divergent_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .decoded_mem_read_enable(rd), .decoded_mem_write_enable(wr), .decoded_ret(ret),
    .fetcher_state(fetcher_state), .lsu_state(lsu_state), .next_pc(next_pc),
    .current_pc(current_pc), .thread_mask(thread_mask), .diverged(diverged),
    .core_state(core_state), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_state(input logic [2:0] s);
    int n = 0;
    do begin
      tick();
      n++;
    end while (core_state != s && n < 60);
    if (core_state != s) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_state: got state %0d expected %0d", core_state, s);
    end
  endtask
  task automatic launch(input logic [2:0] tc);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    start = 1'b1;
    thread_count = tc;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    vec_t v;
    exp_t e;
    vecs.push_back('{1'b1, 8'd0, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, 8'd1, 4'hF, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'd1, {8'd2, 8'd2, 8'd2, 8'd2}, 1'b0, 8'd2, 4'hF, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'd2, {8'd0, 8'd0, 8'd0, 8'd0}, 1'b1, 8'd2, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'd0, {8'd5, 8'd5, 8'd5, 8'd5}, 1'b0, 8'd5, 4'hF, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'd5, {8'd9, 8'd9, 8'd6, 8'd6}, 1'b0, 8'd6, 4'h3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'd6, {8'h33, 8'h33, 8'd7, 8'd7}, 1'b0, 8'd7, 4'h3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'd7, {8'h33, 8'h33, 8'd8, 8'd8}, 1'b0, 8'd8, 4'h3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'd8, {8'h33, 8'h33, 8'd9, 8'd9}, 1'b0, 8'd9, 4'hF, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'd9, {8'd8, 8'd8, 8'd4, 8'd4}, 1'b0, 8'd4, 4'h3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'd4, {8'h33, 8'h33, 8'h44, 8'h44}, 1'b1, 8'd8, 4'hC, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'd8, {8'h55, 8'h55, 8'h55, 8'h55}, 1'b1, 8'd8, 4'h0, 1'b0, 1'b1});
    tick();
    chk("rst_state", core_state, 0);
    chk("rst_pc", current_pc, 0);
    chk("rst_mask", thread_mask, 0);
    chk("rst_div", diverged, 0);
    chk("rst_done", done, 0);
    foreach (vecs[k]) begin
      v = vecs[k];
      if (v.launch) launch(3'd4);
      wait_state(3'd5);
      chk($sformatf("v%0d_pc_in", k), current_pc, v.pc);
      next_pc = v.npc;
      ret = v.ret;
      sb.push_back('{v.epc, v.emask, v.ediv, v.edone});
      tick();
      tick();
      e = sb.pop_front();
      chk($sformatf("v%0d_pc", k), current_pc, e.pc);
      chk($sformatf("v%0d_mask", k), thread_mask, e.mask);
      chk($sformatf("v%0d_div", k), diverged, e.div);
      chk($sformatf("v%0d_done", k), done, e.done);
      chk($sformatf("v%0d_state", k), core_state, e.done ? 7 : 1);
      if (k == 2) chk("start_to_done_cycles", cyc - t0, 18);
      ret = 1'b0;
    end
    launch(3'd2);
    chk("tc2_mask", thread_mask, 4'h3);
    fetcher_state = 3'b000;
    tick();
    tick();
    chk("fetch_hold", core_state, 1);
    fetcher_state = 3'b010;
    wait_state(3'd3);
    lsu_state[3] = 2'b01;
    tick();
    chk("wait_masked_off_1", core_state, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wait_masked_off_2", core_state, 5);
    lsu_state = '0;
    next_pc = {8'd0, 8'd0, 8'd3, 8'd3};
    tick();
    tick();
    chk("tc2_pc", current_pc, 3);
    chk("tc2_mask_after", thread_mask, 4'h3);
    chk("tc2_div", diverged, 0);
    wait_state(3'd3);
    lsu_state[0] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("wait_busy_%0d", i), core_state, 4);
    end
    lsu_state = '0;
    tick();
    chk("wait_release", core_state, 5);
    launch(3'd0);
    chk("tc0_state", core_state, 7);
    chk("tc0_done", done, 1);
    chk("tc0_mask", thread_mask, 0);
    launch(3'd7);
    chk("tc7_mask", thread_mask, 4'hF);
    chk("tc7_state", core_state, 1);
    wait_state(3'd5);
    next_pc = {4{8'h21}};
    tick();
    tick();
    chk("tc7_pc", current_pc, 8'h21);
    wait_state(3'd3);
    lsu_state[0] = 2'b01;
    tick();
    chk("pre_reset_wait", core_state, 4);
    reset = 1'b0;
    start = 1'b1;
    tick();
    chk("mid_rst_state", core_state, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pc", current_pc, 0);
    chk("mid_rst_mask", thread_mask, 0);
    chk("mid_rst_div", diverged, 0);
    tick();
    chk("rst_beats_start", core_state, 0);
    reset = 1'b1;
    start = 1'b0;
    lsu_state = '0;
    tick();
    chk("idle_hold", core_state, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/divergent_scheduler.md
Name: divergent_scheduler

Overview:
Per-core control-flow sequencer that runs one block of up to THREADS_PER_BLOCK threads through the FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE cycle. It supports branch divergence with a per-thread PC, min-PC scheduling and a thread activity mask, so threads reconverge automatically. It supports a runtime thread count below the compile-time maximum. It sits between the fetcher/decoder/LSUs/PC units and the core's register/ALU lanes, which use thread_mask to gate writeback.

Parameters:
THREADS_PER_BLOCK, 4, maximum threads per block (≥1)
PC_WIDTH, 8, program counter width in bits
TC_WIDTH, $clog2(THREADS_PER_BLOCK+1), width of thread_count

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low; 0 at a rising edge resets the block
start  input  1  launch block; sampled only in IDLE
thread_count  input  TC_WIDTH  number of enabled threads, latched at launch
decoded_mem_read_enable  input  1  decoded load (informational; WAIT relies on lsu_state)
decoded_mem_write_enable  input  1  decoded store (informational)
decoded_ret  input  1  current instruction is RET
fetcher_state  input  3  3'b010 = FETCHED
lsu_state  input  [THREADS_PER_BLOCK][2]  per-thread LSU state; 01 = REQUESTING, 10 = WAITING
next_pc  input  [THREADS_PER_BLOCK][PC_WIDTH]  per-thread computed next PC
current_pc  output  PC_WIDTH  PC of the instruction being executed
thread_mask  output  THREADS_PER_BLOCK  threads executing the current instruction
diverged  output  1  thread_mask ≠ set of live threads
core_state  output  3  IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111
done  output  1  block finished

Behaviour:
- Internal state: thread_pc[i] (PC_WIDTH), enabled[i], finished[i].
- Reset (reset==0 at clk edge, from any state): core_state=IDLE, current_pc=0, thread_mask=0, diverged=0, done=0, all thread_pc=0, enabled=0, finished=0. Reset takes priority over all other inputs.
- IDLE, start=1:
  - enabled[i] = (i < min(thread_count, THREADS_PER_BLOCK)); finished=0; thread_pc=0; current_pc=0; thread_mask=enabled.
  - If enabled≠0, go to FETCH.
  - If thread_count=0, go to DONE with done=1 on the same edge.
- IDLE, start=0: hold.
- start is ignored in every state except IDLE.
- FETCH: go to DECODE when fetcher_state==3'b010; otherwise hold.
- DECODE: go to REQUEST after 1 cycle. REQUEST: go to WAIT after 1 cycle.
- WAIT: hold while any thread i with thread_mask[i]=1 has lsu_state[i] ∈ {01,10}; otherwise go to EXECUTE. lsu_state of masked-off threads is ignored.
- EXECUTE: go to UPDATE after 1 cycle.
- UPDATE (single cycle), for each thread with thread_mask[i]=1:
  - decoded_ret=1: finished[i]=1.
  - decoded_ret=0: thread_pc[i]=next_pc[i].
  - Unmasked threads keep thread_pc and ignore next_pc.
- UPDATE next-PC selection, computed combinationally from post-update values:
  - live = enabled & ~finished.
  - live=0: done=1, thread_mask=0, diverged=0, go to DONE; current_pc holds.
  - Otherwise: sel = unsigned minimum of thread_pc over live threads; current_pc=sel; thread_mask = live threads with thread_pc==sel; diverged=(thread_mask≠live); go to FETCH.
- Reconvergence is implicit: threads whose PCs become equal rejoin the mask at the next UPDATE.
- PC arithmetic is done by the PC units; this block only compares values. No wrap handling: next_pc values are taken verbatim.
- DONE: all outputs hold and done stays 1 until reset.
- Latency: minimum 6 cycles per instruction (FETCH with immediate FETCHED through UPDATE); WAIT and FETCH extend it.

Test Plan:
- thread_count=4; every instruction has next_pc=pc+1, fetch immediate, LSUs idle; RET at pc=2 -> current_pc steps 0,1,2; thread_mask=4'b1111 and diverged=0 throughout; done=1 and core_state=111 on the edge leaving the UPDATE for pc=2; 18 cycles start-to-done.
- At pc=5, threads 0,1 have next_pc=6 and threads 2,3 have next_pc=9 -> current_pc=6, thread_mask=0011, diverged=1. Threads 0,1 then proceed 6,7,8 and reach next_pc=9 -> current_pc=9, thread_mask=1111, diverged=0.
- thread_count=2; in WAIT, lsu_state[3]=01 held -> EXECUTE after 1 WAIT cycle. Then lsu_state[0]=10 for 3 cycles -> core_state stays 100 for exactly 3 cycles, then 101.
- Threads 0,1 execute RET at pc=4 while threads 2,3 wait at pc=8 -> current_pc=8, thread_mask=1100, done=0. Threads 2,3 then RET -> done=1.
- start with thread_count=0 -> core_state=111 and done=1 on the next edge; thread_count=7 (THREADS_PER_BLOCK=4) -> thread_mask=1111.
- reset driven 0 during WAIT with lsu busy -> on the next edge core_state=000, done=0, current_pc=0, thread_mask=0; start asserted with reset=0 is ignored.
